// File: rtl/branch_pkg.sv
// branch_pkg: shared opcodes, branch condition encodings and table types for the branch predictor
//   OPC_*       : RV32 control-transfer opcodes
//   br_func3_e  : B-type condition encodings
//   ctr_t       : direction counter at the default width
//   btb_entry_t : {valid, tag, target} at the default geometry
package branch_pkg;
    localparam int XLEN_DEF    = 32;
    localparam int ENTRIES_DEF = 64;
    localparam int CTR_W_DEF   = 2;
    localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
    localparam int TAG_W_DEF   = XLEN_DEF - IDX_W_DEF - 2;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_func3_e;
    typedef logic [CTR_W_DEF-1:0] ctr_t;
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
    } btb_entry_t;
endpackage

// File: rtl/bht_btb_table.sv
// bht_btb_table: direct-mapped direction counters plus BTB, one combinational read port and one synchronous write port
//   clk, rst_n          : clock, synchronous active-low reset (counters weakly not-taken, valids cleared)
//   rd_pc               : lookup PC; rd_taken = hit && counter MSB, rd_target = hit ? target : rd_pc+4
//   wr_ctr_en           : update the counter at wr_pc (wr_force -> saturate to max, else +/-1 by wr_taken)
//   wr_btb_en           : write {valid, tag, wr_target} at wr_pc
module bht_btb_table
    import branch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int CTR_W   = CTR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_ctr_en,
    input  logic            wr_taken,
    input  logic            wr_force,
    input  logic            wr_btb_en,
    input  logic [XLEN-1:2] wr_pc,
    input  logic [XLEN-1:0] wr_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d [ENTRIES];
    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] tag_d [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic [IDX_W-1:0] ri, wi;
    logic [CTR_W-1:0] cur;
    logic             hit;
    assign ri        = rd_pc[IDX_W+1:2];
    assign wi        = wr_pc[IDX_W+1:2];
    assign cur       = ctr_q[wi];
    assign hit       = valid_q[ri] && tag_q[ri] == rd_pc[XLEN-1:IDX_W+2];
    assign rd_taken  = hit && ctr_q[ri][CTR_W-1];
    assign rd_target = hit ? target_q[ri] : rd_pc + XLEN'(4);
    always_comb begin
        ctr_d    = ctr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_ctr_en)
            ctr_d[wi] = wr_force ? '1 :
                        wr_taken ? (&cur ? cur : cur + CTR_W'(1)) :
                                   (|cur ? cur - CTR_W'(1) : cur);
        if (wr_btb_en) begin
            valid_d[wi]  = 1'b1;
            tag_d[wi]    = wr_pc[XLEN-1:IDX_W+2];
            target_d[wi] = wr_target;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i]   <= CTR_INIT;
                valid_q[i] <= 1'b0;
            end
        end else begin
            ctr_q    <= ctr_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BHT/BTB prediction at IF, branch/JAL/JALR resolution in EX, registered redirect and perf counters
//   pc_if -> pred_taken_if, pred_target_if          : combinational prediction (read-before-write)
//   valid_ex, stall_ex, opcode/func3/pc/imm/alu/flags : EX-stage resolve inputs
//   pred_taken_ex, pred_target_ex                   : prediction carried down from IF
//   redirect_valid, redirect_pc                     : registered 1-cycle flush and correct next PC
//   branch_taken_ex                                 : resolved direction of the active EX instruction
//   br_count, mispred_count                         : wrapping resolve and mispredict counters
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int CTR_W   = CTR_W_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_if,
    output logic             pred_taken_if,
    output logic [XLEN-1:0]  pred_target_if,
    input  logic             valid_ex,
    input  logic             stall_ex,
    input  logic [6:0]       opcode_ex,
    input  logic [2:0]       func3_ex,
    input  logic [XLEN-1:0]  pc_ex,
    input  logic [XLEN-1:0]  imm_ex,
    input  logic [XLEN-1:0]  alu_out_ex,
    input  logic             carry_ex,
    input  logic             zero_ex,
    input  logic             negative_ex,
    input  logic             overflow_ex,
    input  logic             pred_taken_ex,
    input  logic [XLEN-1:0]  pred_target_ex,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             branch_taken_ex,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic             is_br, is_jal, is_jalr, is_jump, active, resolve, cond, f3_ok, taken, mispred;
    logic [XLEN-1:0]  target;
    // While a redirect is out, whatever sits in EX is wrong-path and must not resolve.
    assign active  = valid_ex && !stall_ex && !redirect_valid_q;
    assign is_br   = opcode_ex == OPC_BRANCH;
    assign is_jal  = opcode_ex == OPC_JAL;
    assign is_jalr = opcode_ex == OPC_JALR;
    assign is_jump = is_jal || is_jalr;
    assign resolve = active && (is_br || is_jump);
    always_comb begin
        cond  = 1'b0;
        f3_ok = 1'b1;
        case (br_func3_e'(func3_ex))
            F3_BEQ:  cond = zero_ex;
            F3_BNE:  cond = !zero_ex;
            F3_BLT:  cond = negative_ex ^ overflow_ex;
            F3_BGE:  cond = !(negative_ex ^ overflow_ex);
            F3_BLTU: cond = !carry_ex;
            F3_BGEU: cond = carry_ex;
            default: f3_ok = 1'b0;
        endcase
    end
    assign taken           = resolve && (is_jump || cond);
    assign target          = is_jalr ? alu_out_ex & ~XLEN'(1) : pc_ex + imm_ex;
    assign mispred         = resolve && (taken != pred_taken_ex || (taken && target != pred_target_ex));
    assign branch_taken_ex = taken;
    always_comb begin
        redirect_valid_d = mispred;
        redirect_pc_d    = mispred ? (taken ? target : pc_ex + XLEN'(4)) : redirect_pc_q;
        br_count_d       = br_count_q + CNT_W'(resolve);
        mispred_count_d  = mispred_count_q + CNT_W'(mispred);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;
    // Branches with an undefined condition still count as resolved but never train.
    bht_btb_table #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (pc_if),
        .rd_taken  (pred_taken_if),
        .rd_target (pred_target_if),
        .wr_ctr_en (resolve && (is_jump || f3_ok)),
        .wr_taken  (taken),
        .wr_force  (is_jump),
        .wr_btb_en (taken),
        .wr_pc     (pc_ex[XLEN-1:2]),
        .wr_target (target)
    );
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: scoreboard bench for branch_predict_resolve
module tb_branch_predict_resolve;
    import branch_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_if = '0;
    logic        valid_ex = 1'b0, stall_ex = 1'b0;
    logic [6:0]  opcode_ex = '0;
    logic [2:0]  func3_ex = '0;
    logic [31:0] pc_ex = '0, imm_ex = '0, alu_out_ex = '0, pred_target_ex = '0;
    logic        carry_ex = 1'b0, zero_ex = 1'b0, negative_ex = 1'b0, overflow_ex = 1'b0, pred_taken_ex = 1'b0;
    logic        pred_taken_if, redirect_valid, branch_taken_ex;
    logic [31:0] pred_target_if, redirect_pc, br_count, mispred_count;
    logic        pred_taken_if4, redirect_valid4, branch_taken_ex4;
    logic [31:0] pred_target_if4, redirect_pc4;
    logic [3:0]  br_count4, mispred_count4;
    int          checks = 0, failures = 0;
    int          exp_br = 0, exp_mis = 0;
    typedef struct { logic rv; logic [31:0] pc; logic [31:0] br; logic [31:0] mis; string nm; } exp_t;
    exp_t        sbq[$];

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .valid_ex(valid_ex), .stall_ex(stall_ex), .opcode_ex(opcode_ex), .func3_ex(func3_ex), .pc_ex(pc_ex),
        .imm_ex(imm_ex), .alu_out_ex(alu_out_ex), .carry_ex(carry_ex), .zero_ex(zero_ex),
        .negative_ex(negative_ex), .overflow_ex(overflow_ex), .pred_taken_ex(pred_taken_ex),
        .pred_target_ex(pred_target_ex), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_taken_ex(branch_taken_ex), .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_predict_resolve #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_taken_if(pred_taken_if4), .pred_target_if(pred_target_if4),
        .valid_ex(valid_ex), .stall_ex(stall_ex), .opcode_ex(opcode_ex), .func3_ex(func3_ex), .pc_ex(pc_ex),
        .imm_ex(imm_ex), .alu_out_ex(alu_out_ex), .carry_ex(carry_ex), .zero_ex(zero_ex),
        .negative_ex(negative_ex), .overflow_ex(overflow_ex), .pred_taken_ex(pred_taken_ex),
        .pred_target_ex(pred_target_ex), .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .branch_taken_ex(branch_taken_ex4), .br_count(br_count4), .mispred_count(mispred_count4)
    );

    task automatic pred_check(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input string nm);
        pc_if = pc;
        #1;
        checks++;
        if (pred_taken_if !== tk || pred_target_if !== tgt) begin
            failures++;
            $display("FAIL %s: pred got %0b/%h want %0b/%h", nm, pred_taken_if, pred_target_if, tk, tgt);
        end
    endtask

    // Drive one EX instruction for one cycle; the expected redirect is queued and checked after the edge.
    task automatic ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] alu, input logic [3:0] cznv, input logic pt, input logic [31:0] ptg,
                      input logic tk, input logic cnt, input logic rv, input logic [31:0] rpc, input string nm);
        exp_t e;
        opcode_ex = op; func3_ex = f3; pc_ex = pc; imm_ex = imm; alu_out_ex = alu;
        {carry_ex, zero_ex, negative_ex, overflow_ex} = cznv;
        pred_taken_ex = pt; pred_target_ex = ptg; valid_ex = 1'b1;
        exp_br += int'(cnt);
        exp_mis += int'(rv);
        e.rv = rv; e.pc = rpc; e.br = exp_br; e.mis = exp_mis; e.nm = nm;
        sbq.push_back(e);
        #1;
        checks++;
        if (branch_taken_ex !== tk) begin
            failures++;
            $display("FAIL %s taken: got %0b want %0b", nm, branch_taken_ex, tk);
        end
        @(posedge clk);
        #1;
        valid_ex = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.pc)) begin
            failures++;
            $display("FAIL %s redirect: got %0b/%h want %0b/%h", e.nm, redirect_valid, redirect_pc, e.rv, e.pc);
        end
        checks++;
        if (br_count !== e.br || mispred_count !== e.mis) begin
            failures++;
            $display("FAIL %s counts: got %0d/%0d want %0d/%0d", e.nm, br_count, mispred_count, e.br, e.mis);
        end
    endtask

    task automatic idle(input string nm);
        @(posedge clk);
        #1;
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: redirect_valid got %0b want 0", nm, redirect_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_br = 0; exp_mis = 0;
        pred_check(32'h100, 1'b0, 32'h104, "reset_pred");
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || br_count !== 32'h0 || mispred_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got rv=%0b pc=%h br=%0d mis=%0d want 0", redirect_valid, redirect_pc, br_count, mispred_count);
        end
    endtask

    task automatic test_beq();
        ex(OPC_BRANCH, 3'b000, 32'h100, 32'h20, 32'h0, 4'b0100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h120, "beq");
        idle("beq");
        pred_check(32'h100, 1'b1, 32'h120, "beq_trained");
    endtask

    task automatic test_conditions();
        ex(OPC_BRANCH, 3'b100, 32'h30C, 32'h10, 32'h0, 4'b0011, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "blt");
        ex(OPC_BRANCH, 3'b111, 32'h208, 32'h38, 32'h0, 4'b1000, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h240, "bgeu");
        idle("bgeu");
        ex(OPC_BRANCH, 3'b010, 32'h50, 32'h10, 32'h0, 4'b0100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "bad_f3");
        pred_check(32'h50, 1'b0, 32'h54, "bad_f3_untrained");
        ex(OPC_BRANCH, 3'b000, 32'hFFFFFFF0, 32'h20, 32'h0, 4'b0100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, "wrap_tgt");
        idle("wrap_tgt");
        ex(OPC_BRANCH, 3'b001, 32'hFFFFFFFC, 32'h8, 32'h0, 4'b0100, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h0, "wrap_pc4");
        idle("wrap_pc4");
        ex(7'b0110011, 3'b000, 32'h60, 32'h8, 32'h0, 4'b0100, 1'b1, 32'h68, 1'b0, 1'b0, 1'b0, 32'h0, "non_ctrl");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++)
            ex(OPC_BRANCH, 3'b000, 32'h410, 32'h10, 32'h0, 4'b0100, 1'b1, 32'h420, 1'b1, 1'b1, 1'b0, 32'h0, "sat_taken");
        pred_check(32'h410, 1'b1, 32'h420, "sat_max");
        ex(OPC_BRANCH, 3'b000, 32'h410, 32'h10, 32'h0, 4'b0000, 1'b1, 32'h420, 1'b0, 1'b1, 1'b1, 32'h414, "sat_nt1");
        idle("sat_nt1");
        pred_check(32'h410, 1'b1, 32'h420, "sat_ctr2");
        ex(OPC_BRANCH, 3'b000, 32'h410, 32'h10, 32'h0, 4'b0000, 1'b1, 32'h420, 1'b0, 1'b1, 1'b1, 32'h414, "sat_nt2");
        idle("sat_nt2");
        pred_check(32'h410, 1'b0, 32'h420, "sat_ctr1");
    endtask

    task automatic test_back_to_back();
        ex(OPC_JALR, 3'b000, 32'h514, 32'h0, 32'h3001, 4'b0000, 1'b1, 32'h3001, 1'b1, 1'b1, 1'b1, 32'h3000, "jalr");
        ex(OPC_JAL, 3'b000, 32'h600, 32'h100, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "wrong_path");
        idle("b2b");
        pred_check(32'h514, 1'b1, 32'h3000, "jalr_trained");
        pred_check(32'h600, 1'b0, 32'h604, "wrong_path_untrained");
    endtask

    task automatic test_stall_reset();
        stall_ex = 1'b1;
        ex(OPC_BRANCH, 3'b000, 32'h700, 32'h20, 32'h0, 4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "stall");
        stall_ex = 1'b0;
        pred_check(32'h700, 1'b0, 32'h704, "stall_untrained");
        ex(OPC_JAL, 3'b000, 32'h704, 32'h40, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h744, "pre_reset");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_br = 0; exp_mis = 0;
        checks++;
        if (redirect_valid !== 1'b0 || br_count !== 32'h0 || mispred_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_redirect: got rv=%0b br=%0d mis=%0d want 0", redirect_valid, br_count, mispred_count);
        end
        pred_check(32'h100, 1'b0, 32'h104, "reset_cleared_table");
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 17; i++)
            ex(OPC_BRANCH, 3'b001, 32'h800, 32'h10, 32'h0, 4'b0100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "wrap_cnt");
        checks++;
        if (br_count4 !== 4'd1 || mispred_count4 !== 4'd0) begin
            failures++;
            $display("FAIL cnt4_wrap: got %0d/%0d want 1/0", br_count4, mispred_count4);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_conditions();
        test_saturation();
        test_back_to_back();
        test_stall_reset();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
